// File: rtl/bus_activity_meter_pkg.sv
// rtl/bus_activity_meter_pkg.sv - shared types and helpers for the bus activity meter
`timescale 1ns/1ps
package lp_meter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } meter_state_e;

  function automatic int width_of_popcount(input int w);
    return $clog2(w + 1);
  endfunction

  // Operands are carried at 64 bits so one helper serves every counter width (w <= 62).
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << w) - 64'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/bus_activity_meter_if.sv
// rtl/bus_activity_meter_if.sv - control, sample and result signals of one meter instance
`timescale 1ns/1ps
interface bus_activity_meter_if import lp_meter_pkg::*; #(
  parameter int W     = 9,
  parameter int CNT_W = 24
) ();
  localparam int PW = width_of_popcount(W);

  logic             start;
  logic             stop;
  logic [W-1:0]     bus_in;
  logic             bus_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] total_trans;
  logic [PW-1:0]    max_trans;
  logic [CNT_W-1:0] sample_cnt;
`ifdef PER_LINE_CNT_EN
  logic [W*CNT_W-1:0] line_cnt;
`endif

  modport master (
    output start, stop, bus_in, bus_valid,
    input  busy, done, total_trans, max_trans, sample_cnt
`ifdef PER_LINE_CNT_EN
    , input line_cnt
`endif
  );

  modport slave (
    input  start, stop, bus_in, bus_valid,
    output busy, done, total_trans, max_trans, sample_cnt
`ifdef PER_LINE_CNT_EN
    , output line_cnt
`endif
  );

endinterface

// File: rtl/bus_activity_meter_popcount.sv
// rtl/bus_activity_meter_popcount.sv - combinational Hamming distance of two W-bit vectors
`timescale 1ns/1ps
module bus_popcount import lp_meter_pkg::*; #(
  parameter int W = 9
) (
  input  logic [W-1:0]                   a,
  input  logic [W-1:0]                   b,
  output logic [width_of_popcount(W)-1:0] count
);
  localparam int PW = width_of_popcount(W);

  logic [W-1:0] diff;

  assign diff = a ^ b;

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + PW'(diff[i]);
    end
  end

endmodule

// File: rtl/bus_activity_meter.sv
// rtl/bus_activity_meter.sv - counts line transitions of an encoded bus over a window
// Optional per-line toggle counters on output line_cnt when PER_LINE_CNT_EN is defined.
`timescale 1ns/1ps
module bus_activity_meter import lp_meter_pkg::*; #(
  parameter int W      = 9,
  parameter int WINDOW = 1024,
  parameter int CNT_W  = 24
) (
  input logic           ck,
  input logic           rst,
  bus_activity_meter_if.slave mif
);
  localparam int PW = width_of_popcount(W);

  meter_state_e     state;
  meter_state_e     state_next;
  logic [W-1:0]     prev;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    max_d;
  logic [PW-1:0]    d;
  logic [CNT_W-1:0] total_sum;
  logic [CNT_W-1:0] cnt_sum;
  logic             clear;
  logic             load_prev;
  logic             count;
  logic             window_hit;

  bus_popcount #(.W(W)) u_popcount (
    .a     (mif.bus_in),
    .b     (prev),
    .count (d)
  );

  assign total_sum  = CNT_W'(sat_add(64'(total), 64'(d), CNT_W));
  assign cnt_sum    = CNT_W'(sat_add(64'(cnt), 64'd1, CNT_W));
  assign window_hit = (WINDOW != 0) && (cnt_sum == CNT_W'(WINDOW));

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // start is checked first everywhere so it always wins over stop and the in-flight sample.
  always_comb begin
    state_next = state;
    clear      = 1'b0;
    load_prev  = 1'b0;
    count      = 1'b0;
    case (state)
      IDLE: begin
        if (mif.start) begin
          clear      = 1'b1;
          state_next = ARM;
        end else if (mif.stop) begin
          state_next = DONE;
        end
      end
      ARM: begin
        if (mif.start) begin
          clear      = 1'b1;
          state_next = ARM;
        end else if (mif.stop) begin
          state_next = DONE;
        end else if (mif.bus_valid) begin
          load_prev  = 1'b1;
          state_next = MEAS;
        end
      end
      MEAS: begin
        if (mif.start) begin
          clear      = 1'b1;
          state_next = ARM;
        end else begin
          if (mif.bus_valid) begin
            count     = 1'b1;
            load_prev = 1'b1;
            if (window_hit) begin
              state_next = DONE;
            end
          end
          if (mif.stop) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (mif.start) begin
          clear      = 1'b1;
          state_next = ARM;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      prev  <= '0;
      total <= '0;
      cnt   <= '0;
      max_d <= '0;
    end else begin
      if (clear) begin
        total <= '0;
        cnt   <= '0;
        max_d <= '0;
      end else if (count) begin
        total <= total_sum;
        cnt   <= cnt_sum;
        if (d > max_d) begin
          max_d <= d;
        end
      end
      if (load_prev) begin
        prev <= mif.bus_in;
      end
    end
  end

  assign mif.busy        = (state == ARM) || (state == MEAS);
  assign mif.done        = (state == DONE);
  assign mif.total_trans = total;
  assign mif.max_trans   = max_d;
  assign mif.sample_cnt  = cnt;

`ifdef PER_LINE_CNT_EN
  logic [W-1:0]            toggled;
  logic [W-1:0][CNT_W-1:0] line_q;

  assign toggled = mif.bus_in ^ prev;

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      line_q <= '0;
    end else if (clear) begin
      line_q <= '0;
    end else if (count) begin
      for (int i = 0; i < W; i++) begin
        line_q[i] <= CNT_W'(sat_add(64'(line_q[i]), 64'(toggled[i]), CNT_W));
      end
    end
  end

  assign mif.line_cnt = line_q;
`endif

endmodule

// File: tb/tb_bus_activity_meter.sv
// tb/tb_bus_activity_meter.sv - self-checking bench for bus_activity_meter
`timescale 1ns/1ps
module tb_bus_activity_meter;

  logic ck = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  bus_activity_meter_if #(.W(9), .CNT_W(24)) ia ();
  bus_activity_meter_if #(.W(8), .CNT_W(24)) ib ();
  bus_activity_meter_if #(.W(8), .CNT_W(4))  ic ();

  bus_activity_meter #(.W(9), .WINDOW(4), .CNT_W(24)) dut_a (.ck(ck), .rst(rst), .mif(ia));
  bus_activity_meter #(.W(8), .WINDOW(0), .CNT_W(24)) dut_b (.ck(ck), .rst(rst), .mif(ib));
  bus_activity_meter #(.W(8), .WINDOW(0), .CNT_W(4))  dut_c (.ck(ck), .rst(rst), .mif(ic));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          st;
    bit          sp;
    bit          v;
    int unsigned bus;
    bit          busy;
    bit          done;
    longint      total;
    longint      mx;
    longint      cnt;
  } vec_t;
  vec_t tbl[8];

  // Reference model: the samples accepted in the current measurement; results follow from them.
  int unsigned mq[3][$];
  bit          m_active[3];
  bit          m_fin[3];
  int          m_win[3]  = '{4, 0, 0};
  int          m_cw[3]   = '{24, 24, 4};
  int unsigned m_mask[3] = '{32'h1FF, 32'hFF, 32'hFF};

  longint other_lines;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input int id, input bit st, input bit sp, input bit v, input int unsigned bus);
    case (id)
      0: begin ia.start = st; ia.stop = sp; ia.bus_valid = v; ia.bus_in = 9'(bus); end
      1: begin ib.start = st; ib.stop = sp; ib.bus_valid = v; ib.bus_in = 8'(bus); end
      default: begin ic.start = st; ic.stop = sp; ic.bus_valid = v; ic.bus_in = 8'(bus); end
    endcase
  endtask

  task automatic tick();
    @(posedge ck);
    #2;
    ia.start = 0; ia.stop = 0; ia.bus_valid = 0;
    ib.start = 0; ib.stop = 0; ib.bus_valid = 0;
    ic.start = 0; ic.stop = 0; ic.bus_valid = 0;
  endtask

  task automatic get_out(input int id, output bit b, output bit dn, output longint t, output longint m, output longint c);
    case (id)
      0: begin b = ia.busy; dn = ia.done; t = ia.total_trans; m = ia.max_trans; c = ia.sample_cnt; end
      1: begin b = ib.busy; dn = ib.done; t = ib.total_trans; m = ib.max_trans; c = ib.sample_cnt; end
      default: begin b = ic.busy; dn = ic.done; t = ic.total_trans; m = ic.max_trans; c = ic.sample_cnt; end
    endcase
  endtask

  task automatic check_dut(input int id, input string tag, input bit eb, input bit ed,
                           input longint et, input longint em, input longint ec);
    bit b, dn;
    longint t, m, c;
    get_out(id, b, dn, t, m, c);
    chk({tag, ".busy"}, longint'(b), longint'(eb));
    chk({tag, ".done"}, longint'(dn), longint'(ed));
    chk({tag, ".total"}, t, et);
    chk({tag, ".max"}, m, em);
    chk({tag, ".cnt"}, c, ec);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_active[i] = 0;
      m_fin[i] = 0;
    end
  endtask

  task automatic model_step(input int id, input bit st, input bit sp, input bit v, input int unsigned bus);
    if (st) begin
      mq[id].delete();
      m_active[id] = 1;
      m_fin[id] = 0;
    end else begin
      if (m_active[id] && v) mq[id].push_back(bus & m_mask[id]);
      if (m_active[id] && (sp || (m_win[id] != 0 && mq[id].size() == m_win[id] + 1))) begin
        m_active[id] = 0;
        m_fin[id] = 1;
      end else if (!m_active[id] && sp) begin
        m_fin[id] = 1;
      end
    end
  endtask

  task automatic model_check(input int id, input string tag);
    longint lim, sum, mx, c;
    lim = (longint'(1) << m_cw[id]) - 1;
    sum = 0;
    mx = 0;
    for (int k = 1; k < mq[id].size(); k++) begin
      longint dd;
      dd = $countones(mq[id][k] ^ mq[id][k-1]);
      sum += dd;
      if (dd > mx) mx = dd;
    end
    c = (mq[id].size() > 0) ? mq[id].size() - 1 : 0;
    check_dut(id, tag, m_active[id], m_fin[id], (sum > lim) ? lim : sum, mx, (c > lim) ? lim : c);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 32'h000, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 32'h000, 1, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 1, 32'h1FF, 1, 0, 9, 9, 1};
    tbl[3] = '{0, 0, 1, 32'h1FF, 1, 0, 9, 9, 2};
    tbl[4] = '{0, 0, 1, 32'h001, 1, 0, 17, 9, 3};
    tbl[5] = '{0, 0, 1, 32'h000, 0, 1, 18, 9, 4};
    tbl[6] = '{0, 0, 1, 32'h0AA, 0, 1, 18, 9, 4};
    tbl[7] = '{0, 1, 0, 32'h000, 0, 1, 18, 9, 4};

    for (int i = 0; i < 3; i++) drive(i, 0, 0, 0, 0);
    #12;
    check_dut(0, "reset_a", 0, 0, 0, 0, 0);
    rst = 0;
    tick();
    check_dut(0, "idle_a", 0, 0, 0, 0, 0);

    for (int i = 0; i < 8; i++) begin
      drive(0, tbl[i].st, tbl[i].sp, tbl[i].v, tbl[i].bus);
      tick();
      check_dut(0, $sformatf("tbl%0d", i), tbl[i].busy, tbl[i].done, tbl[i].total, tbl[i].mx, tbl[i].cnt);
    end

    drive(0, 1, 0, 0, 0);
    tick();
    for (int i = 1; i < 6; i++) begin
      drive(0, 0, 0, 1, tbl[i].bus);
      tick();
      if (i == 5) begin
        check_dut(0, "gap_final", 0, 1, 18, 9, 4);
      end else begin
        for (int g = 0; g < 3; g++) begin
          drive(0, 0, 0, 0, $urandom_range(0, 511));
          tick();
        end
        chk($sformatf("gap%0d.done", i), longint'(ia.done), 0);
      end
    end

    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 32'h000); tick();
    drive(0, 0, 0, 1, 32'h0FF); tick();
    drive(0, 0, 0, 1, 32'h000); tick();
    check_dut(0, "rs_pre", 1, 0, 16, 8, 2);
    drive(0, 1, 1, 1, 32'h1FF); tick();
    check_dut(0, "rs_start", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h1FF); tick();
    check_dut(0, "rs_ref", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 32'h000); tick();
    check_dut(0, "rs_first", 1, 0, 9, 9, 1);

    drive(0, 1, 0, 0, 0); tick();
    drive(0, 0, 1, 1, 32'h155); tick();
    check_dut(0, "stop_arm", 0, 1, 0, 0, 0);

    drive(1, 1, 0, 0, 0); tick();
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 0, 1, i);
      tick();
    end
    chk("inc.busy", longint'(ib.busy), 1);
    drive(1, 0, 1, 0, 0); tick();
    check_dut(1, "inc", 0, 1, 120, 6, 63);

`ifdef PER_LINE_CNT_EN
    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 32'h00); tick();
    drive(1, 0, 0, 1, 32'h01); tick();
    drive(1, 0, 0, 1, 32'h03); tick();
    drive(1, 0, 0, 1, 32'h01); tick();
    other_lines = 0;
    for (int i = 2; i < 8; i++) other_lines += longint'(ib.line_cnt[i*24 +: 24]);
    chk("pl.line0", longint'(ib.line_cnt[23:0]), 1);
    chk("pl.line1", longint'(ib.line_cnt[47:24]), 2);
    chk("pl.others", other_lines, 0);
    chk("pl.total", longint'(ib.total_trans), 3);
`endif

    drive(2, 1, 0, 0, 0); tick();
    for (int i = 0; i < 20; i++) begin
      drive(2, 0, 0, 1, (i % 2 == 1) ? 32'hFF : 32'h00);
      tick();
    end
    check_dut(2, "sat", 1, 0, 15, 8, 15);

    drive(1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 32'h00); tick();
    drive(1, 0, 0, 1, 32'h0F); tick();
    check_dut(1, "pre_rst", 1, 0, 4, 4, 1);
    rst = 1;
    #0.1;
    check_dut(1, "in_rst", 0, 0, 0, 0, 0);
    #0.1;
    rst = 0;
    #0.1;
    check_dut(1, "post_rst", 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 32'hF0); tick();
    check_dut(1, "rst_idle", 0, 0, 0, 0, 0);
    drive(1, 0, 1, 0, 0); tick();
    check_dut(1, "stop_idle", 0, 1, 0, 0, 0);

    rst = 1;
    #3;
    rst = 0;
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int id = 0; id < 3; id++) begin
        bit st, sp, v;
        int unsigned bus;
        st  = ($urandom_range(0, 24) == 0);
        sp  = ($urandom_range(0, 29) == 0);
        v   = ($urandom_range(0, 2) != 0);
        bus = $urandom() & m_mask[id];
        drive(id, st, sp, v, bus);
        model_step(id, st, sp, v, bus);
      end
      tick();
      for (int id = 0; id < 3; id++) model_check(id, $sformatf("rnd%0d_c%0d", id, cyc));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_activity_meter.md
Name: bus_activity_meter

Overview:
- Downstream consumer of the encoded buses produced by the bus-coding blocks (normal, bus-invert, transition-based, Gray, T0).
- Samples one encoded bus, including any extra INV/INC line, and counts line transitions between consecutive valid samples over a measurement window.
- Reports total transitions, worst-case per-sample transitions and sample count, so encodings can be compared in hardware rather than only through simulator power reports.
- One instance per encoder output.

Parameters:
- W, 9: bus width measured. Use 8 for plain buses and 9 for bus-invert/T0 with the extra line.
- WINDOW, 1024: number of counted transitions intervals per measurement. 0 means free-run until stop. Must be at most 2^CNT_W-1.
- CNT_W, 24: width of the accumulators.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; clears the counters and arms a measurement.
- stop  in  1  single-cycle pulse; ends the measurement early.
- bus_in  in  W  encoded bus under measurement.
- bus_valid  in  1  bus_in holds a new sample this cycle.
- busy  out  1  high in ARM or MEAS.
- done  out  1  high in DONE; results are stable.
- total_trans  out  CNT_W  accumulated Hamming distance; saturating.
- max_trans  out  $clog2(W+1)  largest per-sample Hamming distance.
- sample_cnt  out  CNT_W  number of counted transition intervals.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; the prev register is cleared.
  - busy=0, done=0, total_trans=0, max_trans=0, sample_cnt=0.
- State machine: IDLE, ARM, MEAS, DONE.
  - IDLE: on start, clear all counters and go to ARM.
  - ARM: the first cycle with bus_valid=1 loads prev<=bus_in. Nothing is counted. Go to MEAS.
  - MEAS: each cycle with bus_valid=1:
    - d = popcount(bus_in ^ prev).
    - total_trans += d, saturating at all-ones.
    - max_trans = max(max_trans, d).
    - sample_cnt += 1.
    - prev <= bus_in.
    - When sample_cnt reaches WINDOW on this update (WINDOW!=0), go to DONE. That final sample is counted.
  - MEAS: a stop pulse goes to DONE. If bus_valid is also 1 in that cycle, the sample is counted first.
  - DONE: counters are held and done=1. A start clears the counters and goes to ARM.
- Cycles with bus_valid=0 never update prev or the counters.
- Latency: output registers reflect a sample one cycle after the edge where it was presented. done rises in the same cycle the final counts become visible.
- Simultaneous events:
  - start overrides stop.
  - start during ARM or MEAS restarts: counters are cleared, state goes to ARM, and the in-flight sample is discarded.
- stop in IDLE or ARM goes to DONE with all counts 0.
- Saturation: total_trans sticks at 2^CNT_W-1. sample_cnt cannot overflow because of the WINDOW bound. In free-run (WINDOW=0), sample_cnt also saturates.
- Reset mid-measurement discards all results; no partial result is retained.

Optional Feature:
- Macro: PER_LINE_CNT_EN.
- When defined:
  - Adds output line_cnt, width W*CNT_W. Slice i is the saturating toggle count of bus line i.
  - Updates under the same valid/state rules as total_trans.
  - Cleared by rst and start.
  - The sum of the slices equals total_trans while nothing has saturated.
- When undefined:
  - The port and its counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package lp_meter_pkg holds:
  - the state enum {IDLE, ARM, MEAS, DONE};
  - the function width_of_popcount(W) = $clog2(W+1);
  - the saturating-add helper.
- One sub-module, bus_popcount: combinational XOR-popcount of two W-bit vectors. It is reused by the per-line-disabled and per-line-enabled builds.

Test Plan:
- Reset mid-MEAS with rst pulse 0.2ns: all outputs 0 immediately (async), and the state is IDLE.
- W=9, WINDOW=4; start, then valid samples 0x000, 0x1FF, 0x1FF, 0x001, 0x000 -> total_trans=18, max_trans=9, sample_cnt=4, done=1 one cycle after the fifth sample.
- Same stream with bus_valid deasserted for 3 cycles between samples and bus_in toggling while invalid -> identical results.
- W=8, WINDOW=0; 64-cycle binary-increment sequence 0..63, then stop -> sample_cnt=63, total_trans=120, max_trans=6.
- start asserted during MEAS after 2 counted samples -> counters 0, busy=1, and the next valid sample is reference-only.
- With PER_LINE_CNT_EN, stream 0x00, 0x01, 0x03, 0x01 -> line_cnt[0]=1, line_cnt[1]=2, other slices 0, total_trans=3.
